// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction prefetch queue: word/entry layout and FSM encoding.
package fetch_queue_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FQ_IDLE  = 2'd0,
    FQ_WAIT  = 2'd1,
    FQ_STALE = 2'd2
  } fq_state_e;

  typedef struct packed {
    word_t word;
    word_t pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Ring buffer of {word, pc} entries; flush wins over push and pop.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  fq_entry_t        i_entry,
  input  logic             i_pop,
  input  logic             i_flush,
  output fq_entry_t        o_head,
  output logic [PTR_W:0]   o_count
);

  fq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      // When full, push and pop share a slot: the head is read before this write lands.
      if (i_push) begin
        r_mem[r_wptr] <= i_entry;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (i_pop) r_rptr <= r_rptr + 1'b1;
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (!i_push && i_pop) r_count <= r_count - 1'b1;
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch stage: single-outstanding memory fetch feeding a small FIFO towards decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req,
  output logic [15:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [15:0]      mem_data,
  output logic             ir_valid,
  output logic [15:0]      ir,
  output logic [15:0]      ir_pc,
  input  logic             ir_ready,
  input  logic             redirect,
  input  logic [15:0]      redirect_pc,
  input  logic             halt,
  output logic             busy,
  output fq_state_e        dbg_state,
  output logic [PTR_W:0]   dbg_count
);

  localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

  fq_state_e      r_state;
  fq_state_e      w_state_next;
  logic           r_mem_req;
  word_t          r_mem_addr;
  word_t          r_fetch_pc;
  logic           w_ack;
  logic           w_push;
  logic           w_pop;
  logic           w_issue;
  logic [PTR_W:0] w_count;
  logic [PTR_W:0] w_count_next;
  fq_entry_t      w_head;

  // Decode handshake: an entry transfers on a rising edge where ir_valid && ir_ready;
  // ir_valid never depends on ir_ready, and a redirect in that cycle cancels the transfer.
  assign w_ack        = mem_ack && (r_state != FQ_IDLE);
  assign w_push       = w_ack && (r_state == FQ_WAIT) && !redirect;
  assign w_pop        = (w_count != '0) && ir_ready && !redirect;
  assign w_count_next = w_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
  // Issuing only while a slot remains guarantees the in-flight word can always be stored.
  assign w_issue      = ((r_state == FQ_IDLE) || w_ack) && !halt && !redirect &&
                        (w_count_next < DEPTH_C);

  always_comb begin
    w_state_next = r_state;
    if (redirect) begin
      if (w_ack || (r_state == FQ_IDLE)) w_state_next = FQ_IDLE;
      else                               w_state_next = FQ_STALE;
    end else begin
      case (r_state)
        FQ_IDLE:           if (w_issue) w_state_next = FQ_WAIT;
        FQ_WAIT, FQ_STALE: if (w_ack)   w_state_next = w_issue ? FQ_WAIT : FQ_IDLE;
        default:           w_state_next = FQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= FQ_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      if (w_issue) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + 16'd1;
      end else if (w_ack) begin
        r_mem_req  <= 1'b0;
      end
      if (redirect) r_fetch_pc <= redirect_pc;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_entry ({mem_data, r_mem_addr}),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign ir_valid  = (w_count != '0);
  assign ir        = w_head.word;
  assign ir_pc     = w_head.pc;
  assign busy      = (r_state != FQ_IDLE);
  assign dbg_state = r_state;
  assign dbg_count = w_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: variable-latency memory responder, scoreboard of pushed words, scenario tasks.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             mem_req;
  logic [15:0]      mem_addr;
  logic             mem_ack = 1'b0;
  logic [15:0]      mem_data = '0;
  logic             ir_valid;
  logic [15:0]      ir;
  logic [15:0]      ir_pc;
  logic             ir_ready = 1'b0;
  logic             redirect = 1'b0;
  logic [15:0]      redirect_pc = '0;
  logic             halt = 1'b1;
  logic             busy;
  fq_state_e        dbg_state;
  logic [PTR_W:0]   dbg_count;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .ir_valid(ir_valid), .ir(ir),
    .ir_pc(ir_pc), .ir_ready(ir_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .busy(busy),
    .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [15:0] req_log[$];
  logic        resp_pend = 1'b0;
  logic [15:0] resp_addr = '0;
  int          resp_cnt = 0;
  int          resp_lat = 1;
  logic        stale = 1'b0;
  logic        have_last = 1'b0;
  logic [15:0] last_pc = '0;
  logic        prev_hold = 1'b0;
  logic [15:0] prev_addr = '0;
  int          pop_cnt = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // ---------------- memory responder (drives at posedge+1) ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        mem_ack   = 1'b0;
        resp_pend = 1'b0;
      end else begin
        if (mem_ack) begin
          mem_ack   = 1'b0;
          resp_pend = 1'b0;
        end
        if (!resp_pend && mem_req) begin
          resp_pend = 1'b1;
          resp_addr = mem_addr;
          resp_cnt  = resp_lat;
          req_log.push_back(mem_addr);
        end
        if (resp_pend) begin
          if (resp_cnt <= 1) begin
            mem_ack  = 1'b1;
            mem_data = mem_word(resp_addr);
          end else begin
            resp_cnt--;
          end
        end
      end
    end
  end

  // ---------------- scoreboard monitor (negedge) ----------------
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      stale = 1'b0; have_last = 1'b0; prev_hold = 1'b0; pop_cnt = 0;
    end else begin
      n_checks++;
      if (ir_valid !== (exp_q.size() != 0)) begin
        n_errors++; $display("FAIL sb_ir_valid: got %b expected %b", ir_valid, exp_q.size() != 0);
      end
      if (ir_valid && exp_q.size() != 0) begin
        n_checks++;
        if ({ir, ir_pc} !== exp_q[0]) begin
          n_errors++; $display("FAIL sb_head: got %h expected %h", {ir, ir_pc}, exp_q[0]);
        end
      end
      n_checks++;
      if (int'(dbg_count) !== exp_q.size() || int'(dbg_count) > DEPTH) begin
        n_errors++; $display("FAIL sb_count: got %0d expected %0d", dbg_count, exp_q.size());
      end
      if (prev_hold) begin
        n_checks++;
        if (mem_addr !== prev_addr) begin
          n_errors++; $display("FAIL addr_stable: got %h expected %h", mem_addr, prev_addr);
        end
      end
      prev_hold = mem_req && !mem_ack;
      prev_addr = mem_addr;
      // predict the effect of the coming edge
      if (ir_valid && ir_ready && !redirect && exp_q.size() != 0) begin
        if (have_last) begin
          n_checks++;
          if (ir_pc !== last_pc + 16'd1) begin
            n_errors++; $display("FAIL pc_seq: got %h expected %h", ir_pc, last_pc + 16'd1);
          end
        end
        have_last = 1'b1;
        last_pc   = ir_pc;
        void'(exp_q.pop_front());
        pop_cnt++;
      end
      if (mem_ack && resp_pend) begin
        if (!redirect && !stale) exp_q.push_back({mem_word(resp_addr), resp_addr});
        stale = 1'b0;
      end
      if (redirect) begin
        exp_q.delete();
        have_last = 1'b0;
        if (resp_pend && !mem_ack) stale = 1'b1;
      end
    end
  end

  // ---------------- driver tasks (drive at posedge+2) ----------------
  task automatic do_reset(input logic h, input logic rdy, input int lat);
    @(posedge clk); #2;
    reset = 1'b1; halt = h; ir_ready = rdy; redirect = 1'b0; resp_lat = lat;
    repeat (2) @(posedge clk);
    #2;
    req_log.delete();
    reset = 1'b0;
  endtask

  task automatic wait_log(input int n, input string what);
    for (int i = 0; i < 200 && req_log.size() < n; i++) begin @(posedge clk); #2; end
    n_checks++;
    if (req_log.size() < n) begin
      n_errors++; $display("FAIL %s_timeout: got %0d requests expected %0d", what, req_log.size(), n);
    end
  endtask

  task automatic wait_pend_addr(input logic [15:0] a, input string what);
    for (int i = 0; i < 200 && !(resp_pend && resp_addr == a); i++) begin @(posedge clk); #2; end
    n_checks++;
    if (!(resp_pend && resp_addr == a)) begin
      n_errors++; $display("FAIL %s_pend_timeout: got addr %h expected %h", what, resp_addr, a);
    end
  endtask

  task automatic check_log(input int idx, input logic [15:0] a, input string what);
    n_checks++;
    if (req_log.size() <= idx) begin
      n_errors++; $display("FAIL %s_log%0d: got no request expected %h", what, idx, a);
    end else if (req_log[idx] !== a) begin
      n_errors++; $display("FAIL %s_log%0d: got %h expected %h", what, idx, req_log[idx], a);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(posedge clk); #2;
    n_checks++; if (mem_req !== 1'b0)      begin n_errors++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
    n_checks++; if (mem_addr !== 16'h0000) begin n_errors++; $display("FAIL rst_mem_addr: got %h expected 0000", mem_addr); end
    n_checks++; if (ir_valid !== 1'b0)     begin n_errors++; $display("FAIL rst_ir_valid: got %b expected 0", ir_valid); end
    n_checks++; if ({ir, ir_pc} !== 32'h0) begin n_errors++; $display("FAIL rst_ir: got %h expected 0", {ir, ir_pc}); end
    n_checks++; if (busy !== 1'b0)         begin n_errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_checks++; if (dbg_state !== FQ_IDLE) begin n_errors++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, FQ_IDLE); end
    // release, let a request go outstanding, then reset asynchronously mid-request
    halt = 1'b0; ir_ready = 1'b0; resp_lat = 3; reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (busy !== 1'b1 || mem_req !== 1'b1) begin n_errors++; $display("FAIL midreq_busy: got %b/%b expected 1/1", busy, mem_req); end
    reset = 1'b1; #1;
    n_checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL async_rst: got %b/%b expected 0/0", mem_req, busy); end
    n_checks++; if (dbg_state !== FQ_IDLE || mem_addr !== 16'h0000) begin n_errors++; $display("FAIL async_rst_state: got %0d/%h expected 0/0000", dbg_state, mem_addr); end
  endtask

  task automatic test_stream();
    do_reset(1'b0, 1'b1, 1);
    repeat (12) @(posedge clk);
    #2;
    n_checks++;
    if (req_log.size() !== 12) begin n_errors++; $display("FAIL stream_count: got %0d expected 12", req_log.size()); end
    for (int i = 0; i < 12; i++) check_log(i, 16'(i), "stream");
    n_checks++; if (pop_cnt < 9) begin n_errors++; $display("FAIL stream_pops: got %0d expected >=9", pop_cnt); end
  endtask

  task automatic test_full();
    do_reset(1'b0, 1'b0, 2);
    repeat (30) @(posedge clk);
    #2;
    n_checks++; if (req_log.size() !== 4) begin n_errors++; $display("FAIL full_reqs: got %0d expected 4", req_log.size()); end
    for (int i = 0; i < 4; i++) check_log(i, 16'(i), "full");
    n_checks++; if (dbg_count !== 3'd4) begin n_errors++; $display("FAIL full_count: got %0d expected 4", dbg_count); end
    n_checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL full_req: got %b/%b expected 0/0", mem_req, busy); end
    n_checks++; if (ir_valid !== 1'b1 || ir_pc !== 16'h0000) begin n_errors++; $display("FAIL full_head: got %b/%h expected 1/0000", ir_valid, ir_pc); end
    ir_ready = 1'b1;
    @(posedge clk); #2;
    ir_ready = 1'b0;
    wait_log(5, "full_refill");
    check_log(4, 16'h0004, "full");
    repeat (10) @(posedge clk);
    #2;
    n_checks++; if (req_log.size() !== 5 || dbg_count !== 3'd4) begin n_errors++; $display("FAIL full_again: got %0d/%0d expected 5/4", req_log.size(), dbg_count); end
  endtask

  task automatic test_redirect_wait();
    do_reset(1'b0, 1'b1, 3);
    wait_pend_addr(16'h0005, "rdw");
    redirect = 1'b1; redirect_pc = 16'h0040;
    @(posedge clk); #2;
    redirect = 1'b0;
    n_checks++; if (ir_valid !== 1'b0) begin n_errors++; $display("FAIL rdw_flush: got %b expected 0", ir_valid); end
    n_checks++; if (dbg_state !== FQ_STALE || mem_req !== 1'b1) begin n_errors++; $display("FAIL rdw_stale: got %0d/%b expected %0d/1", dbg_state, mem_req, FQ_STALE); end
    wait_log(7, "rdw");
    check_log(5, 16'h0005, "rdw");
    check_log(6, 16'h0040, "rdw");
    for (int i = 0; i < 20 && !ir_valid; i++) begin @(posedge clk); #2; end
    n_checks++; if (ir_valid !== 1'b1 || ir_pc !== 16'h0040) begin n_errors++; $display("FAIL rdw_head: got %b/%h expected 1/0040", ir_valid, ir_pc); end
  endtask

  task automatic test_redirect_ack();
    do_reset(1'b0, 1'b0, 3);
    wait_pend_addr(16'h0002, "rda");
    for (int i = 0; i < 20 && !mem_ack; i++) begin @(posedge clk); #2; end
    n_checks++; if (mem_ack !== 1'b1) begin n_errors++; $display("FAIL rda_ack_timeout: got %b expected 1", mem_ack); end
    redirect = 1'b1; redirect_pc = 16'h0123;
    @(posedge clk); #2;
    redirect = 1'b0;
    n_checks++; if (dbg_count !== 3'd0 || ir_valid !== 1'b0) begin n_errors++; $display("FAIL rda_count: got %0d/%b expected 0/0", dbg_count, ir_valid); end
    n_checks++; if (dbg_state !== FQ_IDLE || mem_req !== 1'b0) begin n_errors++; $display("FAIL rda_idle: got %0d/%b expected %0d/0", dbg_state, mem_req, FQ_IDLE); end
    wait_log(4, "rda");
    check_log(3, 16'h0123, "rda");
    for (int i = 0; i < 20 && !ir_valid; i++) begin @(posedge clk); #2; end
    n_checks++; if (ir_pc !== 16'h0123 || ir !== mem_word(16'h0123)) begin n_errors++; $display("FAIL rda_head: got %h/%h expected 0123/%h", ir_pc, ir, mem_word(16'h0123)); end
  endtask

  task automatic test_wrap();
    do_reset(1'b1, 1'b1, 1);
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    @(posedge clk); #2;
    redirect = 1'b0; halt = 1'b0;
    wait_log(4, "wrap");
    check_log(0, 16'hFFFE, "wrap");
    check_log(1, 16'hFFFF, "wrap");
    check_log(2, 16'h0000, "wrap");
    check_log(3, 16'h0001, "wrap");
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic test_halt();
    do_reset(1'b0, 1'b1, 3);
    wait_pend_addr(16'h0001, "halt");
    halt = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    n_checks++; if (req_log.size() !== 2) begin n_errors++; $display("FAIL halt_reqs: got %0d expected 2", req_log.size()); end
    n_checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL halt_idle: got %b/%b expected 0/0", mem_req, busy); end
    n_checks++; if (pop_cnt !== 2) begin n_errors++; $display("FAIL halt_pops: got %0d expected 2", pop_cnt); end
    halt = 1'b0;
    wait_log(3, "halt");
    check_log(2, 16'h0002, "halt");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_wait();
    test_redirect_ack();
    test_wrap();
    test_halt();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
